// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Provides the FSM state encoding, length-field sizing and the default idle line level.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic IDLE_LEVEL_DEF = 1'b0;

    // Width needed to hold a frame length of 0..data_w.
    function automatic int len_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Load-command handshake bundle for seq_pattern_tx.
// The command source uses the master modport; the transmitter uses the slave modport.
interface seq_pattern_tx_if #(
    parameter int DATA_W = 8,
    parameter int REP_W  = 4
);
    localparam int LEN_W = seq_pkg::len_w(DATA_W);

    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic [LEN_W-1:0]  load_len;
    logic [REP_W-1:0]  load_rep;

    modport master (
        output load_valid,
        output load_data,
        output load_len,
        output load_rep,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_len,
        input  load_rep,
        output load_ready
    );

endinterface

// File: rtl/seq_piso_shift.sv
// Parallel-load, MSB-first shift register for the pattern transmitter.
// The pattern is left-justified on load so bit len-1 is the first bit out.
module seq_piso_shift #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    input  logic [LEN_W-1:0]  len,
    output logic              msb_next
);

    logic [DATA_W-1:0] sr_r;
    logic [DATA_W-1:0] sr_s;

    // Next register value: load wins over shift; len is always 1..DATA_W here.
    always_comb begin
        sr_s = sr_r;
        if (load) begin
            sr_s = data << (DATA_W - int'(len));
        end else if (shift) begin
            sr_s = {sr_r[DATA_W-2:0], 1'b0};
        end else begin
            sr_s = sr_r;
        end
    end

    // The caller registers this bit so it lines up with the state it is entering.
    assign msb_next = sr_s[DATA_W-1];

    // Shift register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r <= '0;
        end else begin
            sr_r <= sr_s;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a loaded pattern out MSB-first,
// repeating it load_rep+1 times with GAP_CYC idle cycles between frames.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   REP_W      = 4,
    parameter int   GAP_CYC    = 1,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic            clk,
    input  logic            reset,
    seq_pattern_tx_if.slave load,
    input  logic            abort,
    output logic            ser_out,
    output logic            ser_valid,
    output logic            frame_start,
    output logic            busy,
    output logic            done
);

    localparam int LEN_W = len_w(DATA_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    state_t            state_r, state_s;
    logic [LEN_W-1:0]  bit_cnt_r, bit_cnt_s;
    logic [REP_W-1:0]  rep_cnt_r, rep_cnt_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
    logic [DATA_W-1:0] pat_r, pat_s;
    logic [LEN_W-1:0]  len_r, len_s;
    logic [LEN_W-1:0]  eff_len_s;
    logic              accept_s;
    logic              sh_load_s;
    logic              sh_shift_s;
    logic              frame_start_s;
    logic              msb_next_s;

    logic              ser_out_r;
    logic              ser_valid_r;
    logic              frame_start_r;
    logic              busy_r;
    logic              done_r;

    assign load.load_ready = (state_r == IDLE) & ~abort;
    assign accept_s        = load.load_valid & load.load_ready;

    // Zero or oversize lengths select the full pattern width.
    always_comb begin
        if ((load.load_len == '0) || (load.load_len > LEN_W'(DATA_W))) begin
            eff_len_s = LEN_W'(DATA_W);
        end else begin
            eff_len_s = load.load_len;
        end
    end

    // Next-state, counter and shifter-control decode.
    always_comb begin
        state_s       = state_r;
        bit_cnt_s     = bit_cnt_r;
        rep_cnt_s     = rep_cnt_r;
        gap_cnt_s     = gap_cnt_r;
        pat_s         = pat_r;
        len_s         = len_r;
        sh_load_s     = 1'b0;
        sh_shift_s    = 1'b0;
        frame_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s       = SHIFT;
                    pat_s         = load.load_data;
                    len_s         = eff_len_s;
                    rep_cnt_s     = load.load_rep;
                    bit_cnt_s     = eff_len_s - LEN_W'(1);
                    sh_load_s     = 1'b1;
                    frame_start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (bit_cnt_r != '0) begin
                    bit_cnt_s  = bit_cnt_r - LEN_W'(1);
                    sh_shift_s = 1'b1;
                end else if (rep_cnt_r != '0) begin
                    // Counting down to zero gives exactly load_rep+1 frames, no wrap.
                    rep_cnt_s = rep_cnt_r - REP_W'(1);
                    if (GAP_CYC == 0) begin
                        state_s       = SHIFT;
                        bit_cnt_s     = len_r - LEN_W'(1);
                        sh_load_s     = 1'b1;
                        frame_start_s = 1'b1;
                    end else begin
                        state_s   = GAP;
                        gap_cnt_s = GAP_LOAD;
                    end
                end else begin
                    state_s = DONE;
                end
            end
            GAP: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (gap_cnt_r == '0) begin
                    state_s       = SHIFT;
                    bit_cnt_s     = len_r - LEN_W'(1);
                    sh_load_s     = 1'b1;
                    frame_start_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    seq_piso_shift #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load_s),
        .shift    (sh_shift_s),
        .data     (pat_s),
        .len      (len_s),
        .msb_next (msb_next_s)
    );

    // State, counters and latched command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            rep_cnt_r <= '0;
            gap_cnt_r <= '0;
            pat_r     <= '0;
            len_r     <= LEN_W'(DATA_W);
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            rep_cnt_r <= rep_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            pat_r     <= pat_s;
            len_r     <= len_s;
        end
    end

    // Moore outputs registered from the state being entered, so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_out_r     <= IDLE_LEVEL;
            ser_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            ser_out_r     <= (state_s == SHIFT) ? msb_next_s : IDLE_LEVEL;
            ser_valid_r   <= (state_s == SHIFT);
            frame_start_r <= frame_start_s;
            busy_r        <= (state_s != IDLE);
            done_r        <= (state_s == DONE);
        end
    end

    assign ser_out     = ser_out_r;
    assign ser_valid   = ser_valid_r;
    assign frame_start = frame_start_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: one instance with a 1-cycle gap and idle level 0,
// one with no gap and idle level 1, both checked against a cycle-list reference model.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int DATA_W = 8;
    localparam int REP_W  = 4;
    localparam int LEN_W  = len_w(DATA_W);

    logic clk = 1'b0;
    logic reset;
    logic abort_a, abort_b;
    logic so_a, sv_a, fs_a, bz_a, dn_a;
    logic so_b, sv_b, fs_b, bz_b, dn_b;

    int checks = 0;
    int errors = 0;

    // Per-cycle record: {load_ready, busy, done, frame_start, ser_valid, ser_out}
    logic [5:0] obs [2];
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.DATA_W(DATA_W), .REP_W(REP_W)) ifa ();
    seq_pattern_tx_if #(.DATA_W(DATA_W), .REP_W(REP_W)) ifb ();

    seq_pattern_tx #(.DATA_W(DATA_W), .REP_W(REP_W), .GAP_CYC(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .load(ifa), .abort(abort_a),
        .ser_out(so_a), .ser_valid(sv_a), .frame_start(fs_a), .busy(bz_a), .done(dn_a)
    );

    seq_pattern_tx #(.DATA_W(DATA_W), .REP_W(REP_W), .GAP_CYC(0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .load(ifb), .abort(abort_b),
        .ser_out(so_b), .ser_valid(sv_b), .frame_start(fs_b), .busy(bz_b), .done(dn_b)
    );

    assign obs[0] = {ifa.load_ready, bz_a, dn_a, fs_a, sv_a, so_a};
    assign obs[1] = {ifb.load_ready, bz_b, dn_b, fs_b, sv_b, so_b};

    function automatic logic idle_lvl(input int sel);
        return (sel == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic int gap_of(input int sel);
        return (sel == 0) ? 1 : 0;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d,
                         input logic [3:0] l, input logic [3:0] r);
        if (sel == 0) begin
            ifa.load_valid = v; ifa.load_data = d; ifa.load_len = l; ifa.load_rep = r;
        end else begin
            ifb.load_valid = v; ifb.load_data = d; ifb.load_len = l; ifb.load_rep = r;
        end
    endtask

    task automatic set_abort(input int sel, input logic a);
        if (sel == 0) abort_a = a;
        else          abort_b = a;
    endtask

    // Expected cycle list from the frame rules: bits MSB-first per frame, gaps between frames,
    // one done cycle, then an idle cycle with load_ready back.
    task automatic model(input int sel, input logic [7:0] data, input int len_in, input int rep);
        int   len;
        logic il;
        len = (len_in == 0 || len_in > DATA_W) ? DATA_W : len_in;
        il  = idle_lvl(sel);
        exp_q.delete();
        for (int f = 0; f <= rep; f++) begin
            for (int i = len - 1; i >= 0; i--)
                exp_q.push_back({1'b0, 1'b1, 1'b0, (i == len - 1), 1'b1, data[i]});
            if (f < rep)
                for (int g = 0; g < gap_of(sel); g++)
                    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, il});
        end
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, il});
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, il});
    endtask

    // Issue one command and check every cycle through the idle cycle after done.
    // With chain=1 the command is presented in the current (already idle) cycle.
    task automatic run_cmd(input int sel, input logic [7:0] data, input int len, input int rep,
                           input string name, input bit chain, output int hits);
        logic [2:0] win;
        int         nv;
        model(sel, data, len, rep);
        if (!chain) @(negedge clk);
        drive(sel, 1'b1, data, 4'(len), 4'(rep));
        #1;
        checks++;
        if (obs[sel][5] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before got %b exp 1", name, obs[sel][5]);
        end
        @(posedge clk);
        #1;
        // Keep valid high with junk fields while busy; it must be ignored.
        drive(sel, 1'b1, 8'($urandom), 4'($urandom), 4'($urandom));
        hits = 0; win = 3'b000; nv = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if (obs[sel] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s cyc %0d got %b exp %b (rdy,busy,done,fs,valid,out)",
                         name, k + 1, obs[sel], exp_q[k]);
            end
            if (obs[sel][1] === 1'b1) begin
                win = {win[1:0], obs[sel][0]};
                nv++;
                if (nv >= 3 && win == 3'b101) hits++;
            end
            if (k == exp_q.size() - 2) drive(sel, 1'b0, 8'h00, 4'h0, 4'h0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        abort_a = 1'b0; abort_b = 1'b0;
        drive(0, 1'b0, 8'h00, 4'h0, 4'h0);
        drive(1, 1'b0, 8'h00, 4'h0, 4'h0);
        #12;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== {1'b1, 4'b0000, idle_lvl(s)}) begin
                errors++;
                $display("FAIL reset_vals dut%0d got %b exp %b", s, obs[s], {1'b1, 4'b0000, idle_lvl(s)});
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int h;
        run_cmd(0, 8'h05, 3, 0, "basic", 1'b0, h);
    endtask

    task automatic test_repeat_gap();
        int h;
        run_cmd(0, 8'h05, 3, 2, "rep_gap", 1'b0, h);
        checks++;
        if (h != 3) begin
            errors++;
            $display("FAIL det101_count got %0d exp 3", h);
        end
    endtask

    task automatic test_zero_gap();
        int h;
        run_cmd(1, 8'h05, 3, 1, "zero_gap", 1'b0, h);
    endtask

    task automatic test_len_clamp();
        int h;
        run_cmd(0, 8'hA5, 0, 0, "len0", 1'b0, h);
        run_cmd(0, 8'hA5, 15, 0, "len15", 1'b0, h);
        run_cmd(1, 8'hA5, 9, 0, "len9", 1'b0, h);
    endtask

    task automatic test_max_rep();
        int h;
        run_cmd(1, 8'($urandom), 2, 15, "max_rep_b", 1'b0, h);
        run_cmd(0, 8'($urandom), 1, 15, "max_rep_a", 1'b0, h);
    endtask

    task automatic test_back_to_back();
        int h;
        run_cmd(0, 8'($urandom), 4, 1, "b2b_a1", 1'b0, h);
        run_cmd(0, 8'($urandom), 2, 0, "b2b_a2", 1'b1, h);
        run_cmd(1, 8'($urandom), 3, 2, "b2b_b1", 1'b0, h);
        run_cmd(1, 8'($urandom), 5, 0, "b2b_b2", 1'b1, h);
    endtask

    task automatic test_random();
        int h;
        for (int n = 0; n < 12; n++)
            run_cmd(int'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), "random", 1'b0, h);
    endtask

    task automatic test_abort();
        int bad;
        // Abort while the third bit of an 8-bit frame is on the line.
        @(negedge clk);
        drive(0, 1'b1, 8'($urandom), 4'd8, 4'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h00, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (obs[0][1] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_valid got %b exp 1", obs[0][1]);
        end
        set_abort(0, 1'b1);
        @(negedge clk);
        checks++;
        if (obs[0] !== 6'b000000) begin
            errors++;
            $display("FAIL abort_shift got %b exp 000000", obs[0]);
        end
        set_abort(0, 1'b0);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (obs[0] !== 6'b100000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_stays_idle got %0d bad cycles exp 0", bad);
        end
        // Abort with a simultaneous load in IDLE must block acceptance.
        set_abort(1, 1'b1);
        drive(1, 1'b1, 8'hFF, 4'd4, 4'd0);
        #1;
        checks++;
        if (obs[1][5] !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready got %b exp 0", obs[1][5]);
        end
        @(negedge clk);
        checks++;
        if (obs[1][4:1] !== 4'b0000) begin
            errors++;
            $display("FAIL abort_no_accept got %b exp 0000", obs[1][4:1]);
        end
        drive(1, 1'b0, 8'h00, 4'h0, 4'h0);
        set_abort(1, 1'b0);
        // Abort during the done cycle: done still shown, then straight to idle.
        @(negedge clk);
        drive(1, 1'b1, 8'h03, 4'd2, 4'd0);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 8'h00, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (obs[1] !== 6'b011001) begin
            errors++;
            $display("FAIL abort_done_cycle got %b exp 011001", obs[1]);
        end
        set_abort(1, 1'b1);
        @(negedge clk);
        checks++;
        if (obs[1][4:1] !== 4'b0000) begin
            errors++;
            $display("FAIL abort_after_done got %b exp 0000", obs[1][4:1]);
        end
        set_abort(1, 1'b0);
    endtask

    task automatic test_async_reset();
        int h;
        @(negedge clk);
        drive(0, 1'b1, 8'h05, 4'd3, 4'd2);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h00, 4'h0, 4'h0);
        repeat (4) @(negedge clk);
        checks++;
        if (obs[0][4:1] !== 4'b1000) begin
            errors++;
            $display("FAIL in_gap got %b exp 1000", obs[0][4:1]);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (obs[0] !== 6'b100000) begin
            errors++;
            $display("FAIL async_reset got %b exp 100000", obs[0]);
        end
        #1;
        reset = 1'b0;
        run_cmd(0, 8'($urandom), int'($urandom_range(1, 8)), 1, "post_reset", 1'b0, h);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat_gap();
        test_zero_gap();
        test_len_clamp();
        test_max_rep();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
